// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of in-flight conditional branches.
// IF pushes each predicted branch, EX resolves entries by tag, and the ROB pops the
// head at commit. Each pop drives the predictor update port, and a mispredicted
// commit raises a one-cycle redirect and flushes the whole queue.
// Optional feature: define BRQ_STATS_EN to add the commit/mispredict counters.
module branch_resolve_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_push_en,
    input  logic [ADDR_WIDTH-1:0] if_push_pc,
    input  logic                  if_push_pred,
    input  logic [ADDR_WIDTH-1:0] if_push_target,
    output logic                  brq_full,
    output logic [TAG_WIDTH-1:0]  brq_tag,
    input  logic                  ex_res_en,
    input  logic [TAG_WIDTH-1:0]  ex_res_tag,
    input  logic                  ex_res_taken,
    output logic                  brq_head_ready,
    input  logic                  rob_commit_en,
    output logic                  pred_upd_en,
    output logic [ADDR_WIDTH-1:0] pred_upd_pc,
    output logic                  pred_upd_taken,
    output logic                  mispredict,
`ifdef BRQ_STATS_EN
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [31:0]           stat_commits,
    output logic [31:0]           stat_mispredicts
`else
    output logic [ADDR_WIDTH-1:0] redirect_pc
`endif
);

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_resolved;
    logic [DEPTH-1:0]      r_pred;
    logic [DEPTH-1:0]      r_taken;
    logic [ADDR_WIDTH-1:0] r_pc     [DEPTH];
    logic [ADDR_WIDTH-1:0] r_target [DEPTH];
    logic [TAG_WIDTH-1:0]  r_head;
    logic [TAG_WIDTH-1:0]  r_tail;
    logic [TAG_WIDTH:0]    r_count;

    logic w_commit;
    logic w_mispred;
    logic w_push;
    logic w_resolve;

    assign brq_full       = (r_count == (TAG_WIDTH + 1)'(DEPTH));
    assign brq_tag        = r_tail;
    assign brq_head_ready = r_valid[r_head] & r_resolved[r_head];

    // A commit frees the head slot in the same edge, so a full queue may still accept
    // a push alongside a committing head (the new entry lands in the freed slot).
    assign w_commit  = rdy_in & rob_commit_en & brq_head_ready;
    assign w_mispred = w_commit & (r_taken[r_head] != r_pred[r_head]);
    assign w_push    = rdy_in & if_push_en & (~brq_full | w_commit);
    assign w_resolve = rdy_in & ex_res_en & r_valid[ex_res_tag] & ~r_resolved[ex_res_tag]
                     & ~(w_push & (ex_res_tag == r_tail));

    // Queue storage and pointers: push/resolve/commit, full flush on mispredict
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_pred     <= '0;
            r_taken    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc[i]     <= '0;
                r_target[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_mispred) begin
                r_valid    <= '0;
                r_resolved <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_commit) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + TAG_WIDTH'(1);
                end
                if (w_resolve) begin
                    r_resolved[ex_res_tag] <= 1'b1;
                    r_taken[ex_res_tag]    <= ex_res_taken;
                end
                // Push is last so it wins over the commit clear when both hit one slot.
                if (w_push) begin
                    r_valid[r_tail]    <= 1'b1;
                    r_resolved[r_tail] <= 1'b0;
                    r_pred[r_tail]     <= if_push_pred;
                    r_pc[r_tail]       <= if_push_pc;
                    r_target[r_tail]   <= if_push_target;
                    r_tail             <= r_tail + TAG_WIDTH'(1);
                end
                if (w_push && !w_commit) begin
                    r_count <= r_count + (TAG_WIDTH + 1)'(1);
                end else if (!w_push && w_commit) begin
                    r_count <= r_count - (TAG_WIDTH + 1)'(1);
                end
            end
        end
    end

    // Registered predictor-update and redirect pulses, one cycle after a commit
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pred_upd_en    <= 1'b0;
            pred_upd_pc    <= '0;
            pred_upd_taken <= 1'b0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            pred_upd_en <= w_commit;
            mispredict  <= w_mispred;
            if (w_commit) begin
                pred_upd_pc    <= r_pc[r_head];
                pred_upd_taken <= r_taken[r_head];
            end
            if (w_mispred) begin
                redirect_pc <= r_taken[r_head] ? r_target[r_head]
                                               : r_pc[r_head] + ADDR_WIDTH'(4);
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Free-running commit and mispredict counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            stat_commits     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (w_commit) begin
                stat_commits <= stat_commits + 32'd1;
            end
            if (w_mispred) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_push_en = 1'b0;
    logic [31:0] if_push_pc = '0;
    logic        if_push_pred = 1'b0;
    logic [31:0] if_push_target = '0;
    logic        brq_full;
    logic [2:0]  brq_tag;
    logic        ex_res_en = 1'b0;
    logic [2:0]  ex_res_tag = '0;
    logic        ex_res_taken = 1'b0;
    logic        brq_head_ready;
    logic        rob_commit_en = 1'b0;
    logic        pred_upd_en;
    logic [31:0] pred_upd_pc;
    logic        pred_upd_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_mispredicts;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .ADDR_WIDTH(32),
        .DEPTH     (8),
        .TAG_WIDTH (3)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .if_push_en    (if_push_en),
        .if_push_pc    (if_push_pc),
        .if_push_pred  (if_push_pred),
        .if_push_target(if_push_target),
        .brq_full      (brq_full),
        .brq_tag       (brq_tag),
        .ex_res_en     (ex_res_en),
        .ex_res_tag    (ex_res_tag),
        .ex_res_taken  (ex_res_taken),
        .brq_head_ready(brq_head_ready),
        .rob_commit_en (rob_commit_en),
        .pred_upd_en   (pred_upd_en),
        .pred_upd_pc   (pred_upd_pc),
        .pred_upd_taken(pred_upd_taken),
        .mispredict    (mispredict),
`ifdef BRQ_STATS_EN
        .redirect_pc     (redirect_pc),
        .stat_commits    (stat_commits),
        .stat_mispredicts(stat_mispredicts)
`else
        .redirect_pc   (redirect_pc)
`endif
    );

    task automatic idle_inputs();
        rdy_in        = 1'b1;
        if_push_en    = 1'b0;
        ex_res_en     = 1'b0;
        rob_commit_en = 1'b0;
    endtask

    // Let the DUT sample the current inputs, then return to idle 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        if_push_en     = 1'b1;
        if_push_pc     = pc;
        if_push_pred   = pred;
        if_push_target = tgt;
        tick();
    endtask

    task automatic do_resolve(input logic [2:0] tag, input logic taken);
        ex_res_en    = 1'b1;
        ex_res_tag   = tag;
        ex_res_taken = taken;
        tick();
    endtask

    task automatic do_commit();
        rob_commit_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        n_total++; if (brq_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", brq_full); else n_pass++;
        n_total++; if (brq_tag !== 3'd0) $display("FAIL reset_tag got=%0d exp=0", brq_tag); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b0) $display("FAIL reset_head_ready got=%b exp=0", brq_head_ready); else n_pass++;
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL reset_pred_upd_en got=%b exp=0", pred_upd_en); else n_pass++;
        n_total++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got=%b exp=0", mispredict); else n_pass++;
        n_total++; if (redirect_pc !== 32'd0) $display("FAIL reset_redirect got=%h exp=0", redirect_pc); else n_pass++;
        rst_in = 1'b0;
    endtask

    task automatic test_commit();
        apply_reset();
        do_push(32'h100, 1'b1, 32'h180);
        do_resolve(3'd0, 1'b1);
        n_total++; if (brq_head_ready !== 1'b1) $display("FAIL commit_head_ready got=%b exp=1", brq_head_ready); else n_pass++;
        do_commit();
        n_total++; if (pred_upd_en !== 1'b1) $display("FAIL commit_upd_en got=%b exp=1", pred_upd_en); else n_pass++;
        n_total++; if (pred_upd_pc !== 32'h100) $display("FAIL commit_upd_pc got=%h exp=100", pred_upd_pc); else n_pass++;
        n_total++; if (pred_upd_taken !== 1'b1) $display("FAIL commit_upd_taken got=%b exp=1", pred_upd_taken); else n_pass++;
        n_total++; if (mispredict !== 1'b0) $display("FAIL commit_mispredict got=%b exp=0", mispredict); else n_pass++;
        n_total++; if (brq_tag !== 3'd1) $display("FAIL commit_tag got=%0d exp=1", brq_tag); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b0) $display("FAIL commit_head_empty got=%b exp=0", brq_head_ready); else n_pass++;
        tick();
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL commit_pulse_drop got=%b exp=0", pred_upd_en); else n_pass++;
    endtask

    task automatic test_mispredict();
        apply_reset();
        do_push(32'h200, 1'b1, 32'h240);
        do_push(32'h210, 1'b0, 32'h300);
        do_resolve(3'd0, 1'b0);
        do_commit();
        n_total++; if (mispredict !== 1'b1) $display("FAIL mp_pulse got=%b exp=1", mispredict); else n_pass++;
        n_total++; if (redirect_pc !== 32'h204) $display("FAIL mp_redirect got=%h exp=204", redirect_pc); else n_pass++;
        n_total++; if (pred_upd_en !== 1'b1) $display("FAIL mp_upd_en got=%b exp=1", pred_upd_en); else n_pass++;
        n_total++; if (pred_upd_taken !== 1'b0) $display("FAIL mp_upd_taken got=%b exp=0", pred_upd_taken); else n_pass++;
        n_total++; if (brq_tag !== 3'd0) $display("FAIL mp_tag got=%0d exp=0", brq_tag); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b0) $display("FAIL mp_head_ready got=%b exp=0", brq_head_ready); else n_pass++;
        // The flushed tag1 entry must not accept a resolve
        do_resolve(3'd1, 1'b1);
        n_total++; if (mispredict !== 1'b0) $display("FAIL mp_pulse_drop got=%b exp=0", mispredict); else n_pass++;
        n_total++; if (redirect_pc !== 32'h204) $display("FAIL mp_redirect_hold got=%h exp=204", redirect_pc); else n_pass++;
        do_push(32'h400, 1'b0, 32'h480);
        do_push(32'h410, 1'b0, 32'h490);
        do_resolve(3'd0, 1'b0);
        do_commit();
        n_total++; if (pred_upd_pc !== 32'h400) $display("FAIL mp_refill_pc got=%h exp=400", pred_upd_pc); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b0) $display("FAIL mp_tag1_fresh got=%b exp=0", brq_head_ready); else n_pass++;
        // Taken mispredict redirects to the stored target
        do_resolve(3'd1, 1'b1);
        do_commit();
        n_total++; if (mispredict !== 1'b1) $display("FAIL mp_taken_pulse got=%b exp=1", mispredict); else n_pass++;
        n_total++; if (redirect_pc !== 32'h490) $display("FAIL mp_taken_redirect got=%h exp=490", redirect_pc); else n_pass++;
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_push(32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h8000 + 32'(i));
        end
        n_total++; if (brq_full !== 1'b1) $display("FAIL full_flag got=%b exp=1", brq_full); else n_pass++;
        n_total++; if (brq_tag !== 3'd0) $display("FAIL full_tag got=%0d exp=0", brq_tag); else n_pass++;
        do_push(32'hDEAD, 1'b0, 32'hBEEF);
        n_total++; if (brq_tag !== 3'd0) $display("FAIL full_drop_tag got=%0d exp=0", brq_tag); else n_pass++;
        do_resolve(3'd0, 1'b1);
        rob_commit_en = 1'b1;
        do_push(32'h2000, 1'b1, 32'h2100);
        n_total++; if (pred_upd_en !== 1'b1) $display("FAIL full_commit_en got=%b exp=1", pred_upd_en); else n_pass++;
        n_total++; if (pred_upd_pc !== 32'h1000) $display("FAIL full_commit_pc got=%h exp=1000", pred_upd_pc); else n_pass++;
        n_total++; if (brq_full !== 1'b1) $display("FAIL full_stays got=%b exp=1", brq_full); else n_pass++;
        n_total++; if (brq_tag !== 3'd1) $display("FAIL full_wrap_tag got=%0d exp=1", brq_tag); else n_pass++;
        do_resolve(3'd1, 1'b1);
        do_commit();
        n_total++; if (pred_upd_pc !== 32'h1010) $display("FAIL full_next_pc got=%h exp=1010", pred_upd_pc); else n_pass++;
        n_total++; if (brq_full !== 1'b0) $display("FAIL full_after_pop got=%b exp=0", brq_full); else n_pass++;
    endtask

    task automatic test_out_of_order();
        apply_reset();
        do_push(32'h300, 1'b0, 32'h380);
        do_push(32'h310, 1'b0, 32'h390);
        do_push(32'h320, 1'b0, 32'h3A0);
        do_resolve(3'd2, 1'b0);
        n_total++; if (brq_head_ready !== 1'b0) $display("FAIL ooo_head_not_ready got=%b exp=0", brq_head_ready); else n_pass++;
        do_commit();
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL ooo_commit_held got=%b exp=0", pred_upd_en); else n_pass++;
        // Resolve and commit of the head in one cycle: commit must not happen
        ex_res_en = 1'b1; ex_res_tag = 3'd0; ex_res_taken = 1'b0; rob_commit_en = 1'b1;
        tick();
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL ooo_same_cycle got=%b exp=0", pred_upd_en); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b1) $display("FAIL ooo_head_ready got=%b exp=1", brq_head_ready); else n_pass++;
        // Frozen cycle: commit request ignored, no pulse
        rdy_in = 1'b0; rob_commit_en = 1'b1;
        tick();
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL ooo_rdy_freeze got=%b exp=0", pred_upd_en); else n_pass++;
        n_total++; if (brq_head_ready !== 1'b1) $display("FAIL ooo_rdy_hold got=%b exp=1", brq_head_ready); else n_pass++;
        do_commit();
        n_total++; if (pred_upd_pc !== 32'h300) $display("FAIL ooo_commit_pc got=%h exp=300", pred_upd_pc); else n_pass++;
        do_resolve(3'd2, 1'b1);
        do_resolve(3'd1, 1'b0);
        do_commit();
        do_commit();
        n_total++; if (pred_upd_pc !== 32'h320) $display("FAIL ooo_tag2_pc got=%h exp=320", pred_upd_pc); else n_pass++;
        n_total++; if (pred_upd_taken !== 1'b0) $display("FAIL ooo_double_resolve got=%b exp=0", pred_upd_taken); else n_pass++;
        n_total++; if (mispredict !== 1'b0) $display("FAIL ooo_no_mp got=%b exp=0", mispredict); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        do_push(32'h500, 1'b1, 32'h580);
        do_resolve(3'd0, 1'b1);
        do_push(32'h510, 1'b1, 32'h590);
        do_push(32'h520, 1'b0, 32'h5A0);
        do_resolve(3'd1, 1'b1);
        do_commit();
        do_commit();
        do_push(32'h530, 1'b1, 32'h5B0);
        do_resolve(3'd2, 1'b1);
        do_commit();
`ifdef BRQ_STATS_EN
        n_total++; if (stat_commits !== 32'd3) $display("FAIL stats_commits got=%0d exp=3", stat_commits); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'd1) $display("FAIL stats_mispredicts got=%0d exp=1", stat_mispredicts); else n_pass++;
`endif
        n_total++; if (mispredict !== 1'b1) $display("FAIL mid_mp_pulse got=%b exp=1", mispredict); else n_pass++;
        do_push(32'h600, 1'b1, 32'h680);
        do_push(32'h610, 1'b1, 32'h690);
        do_resolve(3'd0, 1'b1);
        do_commit();
        // Assert reset between edges: everything must clear without a clock edge
        #2;
        rst_in = 1'b1;
        #1;
        n_total++; if (pred_upd_en !== 1'b0) $display("FAIL mid_rst_pulse got=%b exp=0", pred_upd_en); else n_pass++;
        n_total++; if (brq_tag !== 3'd0) $display("FAIL mid_rst_tag got=%0d exp=0", brq_tag); else n_pass++;
        n_total++; if (redirect_pc !== 32'd0) $display("FAIL mid_rst_redirect got=%h exp=0", redirect_pc); else n_pass++;
`ifdef BRQ_STATS_EN
        n_total++; if (stat_commits !== 32'd0) $display("FAIL mid_rst_stat_c got=%0d exp=0", stat_commits); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'd0) $display("FAIL mid_rst_stat_m got=%0d exp=0", stat_mispredicts); else n_pass++;
`endif
        rst_in = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          pred;
        bit          resolved;
        bit          taken;
        int          tag;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        int          m_tail;
        bit          m_commit, m_mis, push_ok, hr;
        logic [31:0] e_pc, e_redir;
        bit          e_taken;
        ent_t        ne;
        apply_reset();
        m_tail  = 0;
        e_pc    = '0;
        e_taken = 1'b0;
        e_redir = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in         = ($urandom_range(0, 7) != 0);
            if_push_en     = ($urandom_range(0, 1) == 1);
            if_push_pc     = {$urandom, 2'b00};
            if_push_pred   = 1'($urandom_range(0, 1));
            if_push_target = $urandom;
            ex_res_en      = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                ex_res_tag = 3'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                ex_res_tag = 3'($urandom_range(0, 7));
            ex_res_taken   = ($urandom_range(0, 3) != 0);
            rob_commit_en  = ($urandom_range(0, 2) != 0);
            #1;
            hr = (q.size() > 0) && q[0].resolved;
            n_total++; if (brq_full !== (q.size() == 8)) $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, brq_full, q.size() == 8); else n_pass++;
            n_total++; if (brq_tag !== 3'(m_tail)) $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, brq_tag, m_tail); else n_pass++;
            n_total++; if (brq_head_ready !== hr) $display("FAIL rnd_head_ready cyc=%0d got=%b exp=%b", cyc, brq_head_ready, hr); else n_pass++;

            m_commit = rdy_in && rob_commit_en && hr;
            m_mis    = m_commit && (q[0].taken != q[0].pred);
            if (m_commit) begin
                e_pc    = q[0].pc;
                e_taken = q[0].taken;
            end
            if (m_mis) begin
                e_redir = q[0].taken ? q[0].tgt : q[0].pc + 32'd4;
                q.delete();
                m_tail = 0;
            end else if (rdy_in) begin
                push_ok = if_push_en && (q.size() < 8 || m_commit);
                if (m_commit) void'(q.pop_front());
                if (ex_res_en && !(push_ok && int'(ex_res_tag) == m_tail)) begin
                    foreach (q[k]) begin
                        if (q[k].tag == int'(ex_res_tag) && !q[k].resolved) begin
                            q[k].resolved = 1'b1;
                            q[k].taken    = ex_res_taken;
                        end
                    end
                end
                if (push_ok) begin
                    ne.pc = if_push_pc; ne.tgt = if_push_target; ne.pred = if_push_pred;
                    ne.resolved = 1'b0; ne.taken = 1'b0; ne.tag = m_tail;
                    q.push_back(ne);
                    m_tail = (m_tail + 1) % 8;
                end
            end
            @(posedge clk);
            #1;
            n_total++; if (pred_upd_en !== m_commit) $display("FAIL rnd_upd_en cyc=%0d got=%b exp=%b", cyc, pred_upd_en, m_commit); else n_pass++;
            n_total++; if (mispredict !== m_mis) $display("FAIL rnd_mispredict cyc=%0d got=%b exp=%b", cyc, mispredict, m_mis); else n_pass++;
            n_total++; if (redirect_pc !== e_redir) $display("FAIL rnd_redirect cyc=%0d got=%h exp=%h", cyc, redirect_pc, e_redir); else n_pass++;
            if (m_commit) begin
                n_total++; if (pred_upd_pc !== e_pc) $display("FAIL rnd_upd_pc cyc=%0d got=%h exp=%h", cyc, pred_upd_pc, e_pc); else n_pass++;
                n_total++; if (pred_upd_taken !== e_taken) $display("FAIL rnd_upd_taken cyc=%0d got=%b exp=%b", cyc, pred_upd_taken, e_taken); else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_commit();
        test_mispredict();
        test_full_wrap();
        test_out_of_order();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
